// File: rtl/io_timer_periph.sv
// Memory-mapped GPIO + down-counting timer at 0xF0-0xFF; writes land on the clk edge, reads are combinational.
// No backpressure: every bus access completes in its own cycle; port inputs pass a 2-flop synchronizer.
module io_timer_periph (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] address,
  input  logic       write,
  input  logic [7:0] to_memory,
  output logic [7:0] io_rdata,
  output logic       io_sel,
  input  logic [7:0] port_in0,
  input  logic [7:0] port_in1,
  output logic [7:0] port_out0,
  output logic [7:0] port_out1,
  output logic       irq
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} tmr_state_t;

  tmr_state_t state, state_nxt;
  logic       tmr_en;
  logic       tmr_auto;
  logic [1:0] tmr_pre;
  logic       tmr_ie;
  logic [7:0] tmr_reload;
  logic [7:0] tmr_count;
  logic [5:0] presc;
  logic [5:0] div_m1;
  logic       flag;
  logic [7:0] sync0_a, sync0_b, sync1_a, sync1_b;

  logic wr_en, wr_port0, wr_port1, wr_ctrl, wr_reload, wr_status;
  logic tick, expire, start, pre_chg;

  assign io_sel    = (address[7:4] == 4'hF);
  assign wr_en     = write & io_sel;
  assign wr_port0  = wr_en && (address[3:0] == 4'h0);
  assign wr_port1  = wr_en && (address[3:0] == 4'h1);
  assign wr_ctrl   = wr_en && (address[3:0] == 4'h4);
  assign wr_reload = wr_en && (address[3:0] == 4'h5);
  assign wr_status = wr_en && (address[3:0] == 4'h7);

  always_comb begin
    div_m1 = 6'd0;
    case (tmr_pre)
      2'b00:   div_m1 = 6'd0;
      2'b01:   div_m1 = 6'd3;
      2'b10:   div_m1 = 6'd15;
      default: div_m1 = 6'd63;
    endcase
  end

  assign tick    = tmr_en && (presc == div_m1);
  assign expire  = tick && (tmr_count == 8'd0);
  // A CPU EN=1 write also restarts when a one-shot expiry would drop EN this cycle.
  assign start   = wr_ctrl && to_memory[0] && (!tmr_en || (expire && !tmr_auto));
  assign pre_chg = wr_ctrl && (to_memory[3:2] != tmr_pre);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (wr_ctrl)                    state_nxt = to_memory[0] ? RUN : IDLE;
    else if (expire && !tmr_auto)   state_nxt = IDLE;
  end

  always_comb begin
    tmr_en = (state == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_out0  <= 8'h00;
      port_out1  <= 8'h00;
      sync0_a    <= 8'h00;
      sync0_b    <= 8'h00;
      sync1_a    <= 8'h00;
      sync1_b    <= 8'h00;
      tmr_auto   <= 1'b0;
      tmr_pre    <= 2'b00;
      tmr_ie     <= 1'b0;
      tmr_reload <= 8'h00;
      tmr_count  <= 8'h00;
      presc      <= 6'd0;
      flag       <= 1'b0;
    end else begin
      if (wr_port0) port_out0 <= to_memory;
      if (wr_port1) port_out1 <= to_memory;
      sync0_a <= port_in0;
      sync0_b <= sync0_a;
      sync1_a <= port_in1;
      sync1_b <= sync1_a;
      if (wr_ctrl) begin
        tmr_auto <= to_memory[1];
        tmr_pre  <= to_memory[3:2];
        tmr_ie   <= to_memory[4];
      end
      if (wr_reload) tmr_reload <= to_memory;

      if (start)
        tmr_count <= tmr_reload;
      else if (tick) begin
        if (tmr_count != 8'd0)  tmr_count <= tmr_count - 8'd1;
        else if (tmr_auto)      tmr_count <= tmr_reload;
      end

      if (state_nxt == IDLE || start || pre_chg || tick) presc <= 6'd0;
      else                                               presc <= presc + 6'd1;

      // Expiry set takes priority over a same-cycle write-1-to-clear.
      if (expire)                         flag <= 1'b1;
      else if (wr_status && to_memory[0]) flag <= 1'b0;
    end
  end

  always_comb begin
    io_rdata = 8'h00;
    if (io_sel) begin
      case (address[3:0])
        4'h0:    io_rdata = port_out0;
        4'h1:    io_rdata = port_out1;
        4'h2:    io_rdata = sync0_b;
        4'h3:    io_rdata = sync1_b;
        4'h4:    io_rdata = {3'b000, tmr_ie, tmr_pre, tmr_auto, tmr_en};
        4'h5:    io_rdata = tmr_reload;
        4'h6:    io_rdata = tmr_count;
        4'h7:    io_rdata = {7'b0000000, flag};
        default: io_rdata = 8'h00;
      endcase
    end
  end

  assign irq = flag & tmr_ie;

endmodule

// File: doc/io_timer_periph.md
IO_TIMER_PERIPH -- requirements
Module: io_timer_periph

Interface
REQ-001 SHALL provide one clock and an asynchronous, active-low reset. The clock is named clk and the reset is named reset; reset asserted = 0.
REQ-002 Ports, as name / direction / width / meaning:
- clk / in / 1 / rising-edge clock
- reset / in / 1 / async active-low reset
- address / in / 8 / CPU bus address
- write / in / 1 / CPU write strobe; sampled at clk rise
- to_memory / in / 8 / CPU write data
- io_rdata / out / 8 / read data, combinational from address
- io_sel / out / 1 / 1 when address is in 0xF0-0xFF; the top-level read mux uses it
- port_in0, port_in1 / in / 8 each / asynchronous external inputs
- port_out0, port_out1 / out / 8 each / registered external outputs
- irq / out / 1 / timer interrupt request
REQ-003 SHALL have no parameters; the base address 0xF0 is fixed.

Function
REQ-004 io_sel SHALL equal (address[7:4] == 4'hF); all accesses with io_sel = 0 SHALL be ignored, and io_rdata = 0x00 in that case.
REQ-005 Register map (offset = address[3:0]):
- 0 PORT_OUT0: RW
- 1 PORT_OUT1: RW
- 2 PORT_IN0: RO
- 3 PORT_IN1: RO
- 4 TMR_CTRL: RW; bit0 EN, bit1 AUTO, bits3:2 PRE, bit4 IE, bits7:5 read 0
- 5 TMR_RELOAD: RW
- 6 TMR_COUNT: RO
- 7 TMR_STATUS: bit0 FLAG, write-1-to-clear
- 8-F: read 0x00; writes ignored
REQ-006 A write SHALL take effect at the clk rise where write = 1 and io_sel = 1; read-back of the new value is visible in the following cycle.
REQ-007 port_in0/port_in1 SHALL each pass through a 2-flop synchronizer; PORT_IN reads return the second flop, so latency is 2 clk edges.
REQ-008 port_out0/port_out1 SHALL drive the PORT_OUT registers directly.
REQ-009 Prescaler:
- 6-bit counter, held at 0 while EN = 0.
- Division by PRE: 00 -> /1, 01 -> /4, 10 -> /16, 11 -> /64.
- A tick fires when the counter equals divide-1; the counter returns to 0 on that tick.
REQ-010 Timer states:
- IDLE (EN = 0): COUNT holds its value.
- RUN (EN = 1): on each tick, if COUNT != 0 then COUNT decrements; if COUNT == 0 then FLAG sets and the expiry rule below applies.
REQ-011 Expiry rule, applied on a tick with COUNT == 0:
- AUTO = 1: COUNT reloads from TMR_RELOAD.
- AUTO = 0: EN clears (one-shot), returning to IDLE.
REQ-012 A TMR_CTRL write that takes EN from 0 to 1 SHALL load COUNT from TMR_RELOAD and clear the prescaler in that same edge.
REQ-013 A TMR_CTRL write with EN already 1 SHALL update AUTO/PRE/IE without reloading COUNT; a PRE change SHALL clear the prescaler.
REQ-014 Writing TMR_RELOAD SHALL NOT change COUNT; the new value applies at the next reload.
REQ-015 Simultaneous FLAG set (expiry) and write-1-to-clear in the same cycle: set SHALL win.
REQ-016 Simultaneous one-shot EN auto-clear and a CPU write of EN = 1 in the same cycle: the CPU write SHALL win and reload COUNT.
REQ-017 irq SHALL be FLAG AND IE, registered-free (combinational from the registers).
REQ-018 A reload value of 0 SHALL cause expiry on every tick.

Reset
REQ-019 On reset = 0, immediately and independent of clk: PORT_OUT0/1, synchronizer flops, TMR_CTRL, TMR_RELOAD, COUNT, prescaler and FLAG SHALL all be 0x00/0.
REQ-020 Consequently port_out0 = port_out1 = 0x00 and irq = 0 during reset.
REQ-021 Reset asserted mid-count SHALL abort the timer with no FLAG set; after release the block is in IDLE.
REQ-022 Writes during reset SHALL be ignored.

Verification
REQ-023 Port loop: write 0xA5 to 0xF0, drive port_in1 = 0x3C -> port_out0 = 0xA5 the next cycle; read 0xF3 = 0x3C from the 2nd edge onward; read 0xF9 = 0x00 and io_sel = 1; read 0x10 gives io_sel = 0.
REQ-024 One-shot: RELOAD = 3, CTRL = 0x01 -> COUNT reads 3,2,1,0 on successive cycles; FLAG = 1 on the 5th cycle after the write; EN reads 0; COUNT stays 0 thereafter.
REQ-025 Auto-reload with prescale: RELOAD = 1, CTRL = 0x17 (EN, AUTO, /4, IE) -> FLAG sets every 8 clks; irq = 1 after the first expiry; write 0x01 to 0xF7 -> irq = 0 until the next expiry.
REQ-026 Set/clear collision: time a 0xF7 write of 0x01 onto the expiry cycle -> FLAG reads 1 afterwards.
REQ-027 Reset mid-operation: pulse reset low asynchronously (not clk-aligned) while COUNT = 5 -> all outputs 0x00 and irq = 0 before the next clk edge; COUNT holds 0 after release.
